// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types, LFSR taps and lane X helper for traffic_spawner.
package traffic_pkg;

  typedef logic [9:0] coord_t;
  typedef logic [1:0] lane_t;

  typedef enum logic [1:0] {
    PARKED  = 2'd0,
    PENDING = 2'd1,
    ACTIVE  = 2'd2
  } slot_state_t;

  // Fibonacci taps 8,6,5,4 expressed as a mask over lfsr[7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic coord_t lane_x(input lane_t lane, input int unsigned x0,
                                    input int unsigned pitch);
    return coord_t'(x0 + 32'(lane) * pitch);
  endfunction

endpackage

// File: rtl/lane_lfsr.sv
// lane_lfsr: 8-bit Fibonacci LFSR used for lane selection; holds while hold is high.
module lane_lfsr
  import traffic_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h5A
) (
  input  logic       enemy_clk,
  input  logic       reset,
  input  logic       hold,
  output logic [7:0] lfsr
);

  // shift left, feedback is the parity of the tapped bits
  always_ff @(posedge enemy_clk) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (!hold) begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/traffic_spawner.sv
// traffic_spawner: schedules launches of N enemy movers (lane, X, Y) and the
// shared acceleration value. Optional feature macro: TRAFFIC_ACCEL_EN enables
// the acceleration ramp; without it acceleration is a constant 0.
//
// Slot FSM
//   state   | meaning
//   PARKED  | never launched, waiting for enough gap wraps to be armed
//   PENDING | wants a launch, waiting for the grant
//   ACTIVE  | on the road, waiting for its mover to reach Y_END
module traffic_spawner
  import traffic_pkg::*;
#(
  parameter int unsigned N_ENEMIES  = 2,
  parameter int unsigned N_LANES    = 3,
  parameter int unsigned LANE_X0    = 197,
  parameter int unsigned LANE_PITCH = 82,
  parameter int unsigned Y_START    = 0,
  parameter int unsigned Y_END      = 620,
  parameter int unsigned SPAWN_GAP  = 250,
  parameter int unsigned ACCEL_STEP = 1000,
  parameter int unsigned ACCEL_MAX  = 100000,
  parameter logic [7:0]  LFSR_SEED  = 8'h5A
) (
  input  logic                     enemy_clk,
  input  logic                     reset,
  input  logic                     collision,
  input  logic [10*N_ENEMIES-1:0]  enemy_y,
  output logic [N_ENEMIES-1:0]     spawn_en,
  output logic [10*N_ENEMIES-1:0]  spawn_x,
  output logic [10*N_ENEMIES-1:0]  spawn_y,
  output logic [N_ENEMIES-1:0]     active,
  output logic [24:0]              acceleration
);

  localparam int unsigned GAP_W  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int unsigned WRAP_W = $clog2(N_ENEMIES + 1);
  // lane implied by the reset value of spawn_x
  localparam lane_t DEF_LANE = (N_LANES > 1) ? lane_t'(1) : lane_t'(0);

  if (N_ENEMIES < 1 || N_ENEMIES > 8) begin : g_bad_n_enemies
    $error("traffic_spawner: N_ENEMIES must be 1..8");
  end
  if (N_LANES < 1 || N_LANES > 4) begin : g_bad_n_lanes
    $error("traffic_spawner: N_LANES must be 1..4");
  end
  if (LANE_X0 + (N_LANES - 1) * LANE_PITCH > 1023) begin : g_bad_lane_x
    $error("traffic_spawner: lane X does not fit in 10 bits");
  end
  if (Y_START > 1023 || Y_END > 1023) begin : g_bad_y
    $error("traffic_spawner: Y does not fit in 10 bits");
  end
  if (SPAWN_GAP < 1) begin : g_bad_gap
    $error("traffic_spawner: SPAWN_GAP must be at least 1");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("traffic_spawner: LFSR_SEED must be non-zero");
  end

  logic [GAP_W-1:0]     gap_cnt;
  logic [WRAP_W-1:0]    wrap_cnt;
  logic                 gap_wrap;
  logic [7:0]           lfsr;
  lane_t                prev_lane;
  lane_t                lane_raw;
  lane_t                lane_sel;
  slot_state_t          state_q [N_ENEMIES];
  slot_state_t          state_d [N_ENEMIES];
  logic [N_ENEMIES-1:0] armed;
  logic [N_ENEMIES-1:0] eligible;
  logic [N_ENEMIES-1:0] grant;

  assign gap_wrap = (gap_cnt == GAP_W'(SPAWN_GAP - 1));

  lane_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .enemy_clk (enemy_clk),
    .reset     (reset),
    .hold      (collision),
    .lfsr      (lfsr)
  );

  // gap period timer and saturating count of completed periods
  always_ff @(posedge enemy_clk) begin
    if (reset) begin
      gap_cnt  <= '0;
      wrap_cnt <= '0;
    end else if (!collision) begin
      if (gap_wrap) begin
        gap_cnt <= '0;
        if (wrap_cnt != WRAP_W'(N_ENEMIES)) begin
          wrap_cnt <= wrap_cnt + WRAP_W'(1);
        end
      end else begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

  // a parked slot that is already armed competes for the grant this cycle
  always_comb begin
    armed    = '0;
    eligible = '0;
    for (int k = 0; k < N_ENEMIES; k++) begin
      armed[k]    = (int'(wrap_cnt) >= k);
      eligible[k] = (state_q[k] == PENDING) || ((state_q[k] == PARKED) && armed[k]);
    end
  end

  // fixed-priority arbiter: lowest-index eligible slot wins
  always_comb begin
    grant = '0;
    for (int k = N_ENEMIES - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
      end
    end
  end

  // lane pick from the LFSR, stepping away from the previous grant's lane
  always_comb begin
    lane_raw = lane_t'(lfsr % 8'(N_LANES));
    lane_sel = lane_raw;
    if (N_LANES > 1 && lane_raw == prev_lane) begin
      lane_sel = (32'(lane_raw) == N_LANES - 1) ? lane_t'(0) : lane_raw + lane_t'(1);
    end
  end

  // per-slot next state
  always_comb begin
    for (int k = 0; k < N_ENEMIES; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        PARKED: begin
          if (grant[k]) begin
            state_d[k] = ACTIVE;
          end else if (armed[k]) begin
            state_d[k] = PENDING;
          end
        end
        PENDING: begin
          if (grant[k]) begin
            state_d[k] = ACTIVE;
          end
        end
        ACTIVE: begin
          if (enemy_y[10*k +: 10] == coord_t'(Y_END)) begin
            state_d[k] = PENDING;
          end
        end
        default: state_d[k] = PARKED;
      endcase
    end
  end

  // slot state, launch pulse and launch coordinates; collision freezes all but the pulse
  always_ff @(posedge enemy_clk) begin
    if (reset) begin
      spawn_en  <= '0;
      active    <= '0;
      prev_lane <= DEF_LANE;
      for (int k = 0; k < N_ENEMIES; k++) begin
        state_q[k]          <= PARKED;
        spawn_x[10*k +: 10] <= lane_x(DEF_LANE, LANE_X0, LANE_PITCH);
        spawn_y[10*k +: 10] <= coord_t'(Y_END);
      end
    end else if (collision) begin
      spawn_en <= '0;
    end else begin
      spawn_en <= grant;
      active   <= active | grant;
      if (|grant) begin
        prev_lane <= lane_sel;
      end
      for (int k = 0; k < N_ENEMIES; k++) begin
        state_q[k] <= state_d[k];
        if (grant[k]) begin
          spawn_x[10*k +: 10] <= lane_x(lane_sel, LANE_X0, LANE_PITCH);
          spawn_y[10*k +: 10] <= coord_t'(Y_START);
        end
      end
    end
  end

`ifdef TRAFFIC_ACCEL_EN
  logic [24:0] accel_q;
  logic [25:0] accel_sum;

  assign accel_sum = {1'b0, accel_q} + 26'(ACCEL_STEP);

  // ramp on every gap wrap, clamped at the ceiling
  always_ff @(posedge enemy_clk) begin
    if (reset) begin
      accel_q <= '0;
    end else if (!collision && gap_wrap) begin
      accel_q <= (accel_sum > 26'(ACCEL_MAX)) ? 25'(ACCEL_MAX) : accel_sum[24:0];
    end
  end

  assign acceleration = accel_q;
`else
  assign acceleration = '0;
`endif

endmodule

// File: tb/tb_traffic_spawner.sv
// tb_traffic_spawner: directed scenarios plus randomized traffic checked
// against a behavioural launch model of the scheduler.
module tb_traffic_spawner;

  localparam int N    = 2;
  localparam int L    = 3;
  localparam int X0   = 197;
  localparam int P    = 82;
  localparam int YS   = 0;
  localparam int YE   = 620;
  localparam int GAP  = 250;
  localparam int STEP = 1000;
  localparam int AMAX = 100000;

  logic          enemy_clk = 1'b0;
  logic          reset;
  logic          collision;
  logic [10*N-1:0] enemy_y;
  logic [N-1:0]  spawn_en;
  logic [10*N-1:0] spawn_x;
  logic [10*N-1:0] spawn_y;
  logic [N-1:0]  active;
  logic [24:0]   acceleration;

  logic          collision1;
  logic [9:0]    enemy_y1;
  logic [0:0]    spawn_en1;
  logic [9:0]    spawn_x1;
  logic [9:0]    spawn_y1;
  logic [0:0]    active1;
  logic [24:0]   accel1;

  int n_cmp = 0;
  int n_err = 0;
  int edges = 0;

  // behavioural model state
  int           m_cyc;
  logic [7:0]   m_lfsr;
  int           m_prev;
  bit           m_wait [N];
  bit           m_road [N];
  logic [N-1:0] m_en;
  logic [N-1:0] m_active;
  int           m_x [N];
  int           m_y [N];
  int           m_acc;

  always #5 enemy_clk = ~enemy_clk;

  traffic_spawner u_dut (
    .enemy_clk    (enemy_clk),
    .reset        (reset),
    .collision    (collision),
    .enemy_y      (enemy_y),
    .spawn_en     (spawn_en),
    .spawn_x      (spawn_x),
    .spawn_y      (spawn_y),
    .active       (active),
    .acceleration (acceleration)
  );

  traffic_spawner #(
    .N_ENEMIES (1),
    .N_LANES   (1),
    .SPAWN_GAP (4)
  ) u_dut1 (
    .enemy_clk    (enemy_clk),
    .reset        (reset),
    .collision    (collision1),
    .enemy_y      (enemy_y1),
    .spawn_en     (spawn_en1),
    .spawn_x      (spawn_x1),
    .spawn_y      (spawn_y1),
    .active       (active1),
    .acceleration (accel1)
  );

  function automatic void model_reset();
    m_cyc    = 0;
    m_lfsr   = 8'h5A;
    m_prev   = 1;
    m_en     = '0;
    m_active = '0;
    m_acc    = 0;
    for (int k = 0; k < N; k++) begin
      m_wait[k] = 0;
      m_road[k] = 0;
      m_x[k]    = X0 + P;
      m_y[k]    = YE;
    end
  endfunction

  function automatic void model_step(logic r, logic c, logic [10*N-1:0] y);
    int wraps;
    int win;
    int lane;
    bit ex [N];
    if (r) begin
      model_reset();
      return;
    end
    if (c) begin
      m_en = '0;
      return;
    end
    wraps = m_cyc / GAP;
    if (wraps > N) wraps = N;
    for (int k = 0; k < N; k++)
      if (!m_active[k] && !m_wait[k] && wraps >= k) m_wait[k] = 1;
    win = -1;
    for (int k = N - 1; k >= 0; k--)
      if (m_wait[k]) win = k;
    for (int k = 0; k < N; k++)
      ex[k] = m_road[k] && (int'(y[10*k +: 10]) == YE);
    m_en = '0;
    if (win >= 0) begin
      lane = int'(m_lfsr) % L;
      if (L > 1 && lane == m_prev) lane = (lane + 1) % L;
      m_x[win]      = X0 + lane * P;
      m_y[win]      = YS;
      m_active[win] = 1'b1;
      m_road[win]   = 1;
      m_wait[win]   = 0;
      m_prev        = lane;
      m_en[win]     = 1'b1;
    end
    for (int k = 0; k < N; k++)
      if (ex[k]) begin
        m_road[k] = 0;
        m_wait[k] = 1;
      end
`ifdef TRAFFIC_ACCEL_EN
    if (m_cyc % GAP == GAP - 1) m_acc = (m_acc + STEP > AMAX) ? AMAX : m_acc + STEP;
`endif
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_cyc++;
  endfunction

  task automatic tick();
    logic r;
    logic c;
    logic [10*N-1:0] y;
    r = reset;
    c = collision;
    y = enemy_y;
    @(posedge enemy_clk);
    model_step(r, c, y);
    edges = r ? 0 : edges + 1;
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    collision  = 1'b0;
    enemy_y    = {10'd100, 10'd100};
    collision1 = 1'b0;
    enemy_y1   = 10'd100;
    repeat (3) tick();
    n_cmp++; if (spawn_en !== 2'b00) begin n_err++; $display("FAIL reset_spawn_en: got %b want 00", spawn_en); end
    n_cmp++; if (active !== 2'b00) begin n_err++; $display("FAIL reset_active: got %b want 00", active); end
    n_cmp++; if (acceleration !== 25'd0) begin n_err++; $display("FAIL reset_accel: got %0d want 0", acceleration); end
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (spawn_x[10*k +: 10] !== 10'd279) begin n_err++; $display("FAIL reset_x%0d: got %0d want 279", k, spawn_x[10*k +: 10]); end
      n_cmp++; if (spawn_y[10*k +: 10] !== 10'd620) begin n_err++; $display("FAIL reset_y%0d: got %0d want 620", k, spawn_y[10*k +: 10]); end
    end
    n_cmp++; if (spawn_x1 !== 10'd197) begin n_err++; $display("FAIL reset_x_single: got %0d want 197", spawn_x1); end
  endtask

  task automatic test_first_launch();
    int bad;
    reset = 1'b0;
    tick();
    n_cmp++; if (spawn_en !== 2'b01) begin n_err++; $display("FAIL first_en: got %b want 01", spawn_en); end
    n_cmp++; if (spawn_y[9:0] !== 10'd0) begin n_err++; $display("FAIL first_y: got %0d want 0", spawn_y[9:0]); end
    n_cmp++; if (!(spawn_x[9:0] inside {10'd197, 10'd279, 10'd361})) begin n_err++; $display("FAIL first_x_set: got %0d want a lane X", spawn_x[9:0]); end
    n_cmp++; if (spawn_x[9:0] !== 10'(m_x[0])) begin n_err++; $display("FAIL first_x: got %0d want %0d", spawn_x[9:0], m_x[0]); end
    bad = 0;
    while (edges < 250) begin
      tick();
      if (spawn_en !== 2'b00) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL gap_quiet: got %0d pulses want 0", bad); end
    tick();
    n_cmp++; if (spawn_en !== 2'b10) begin n_err++; $display("FAIL slot1_en_251: got %b want 10", spawn_en); end
    n_cmp++; if (active !== 2'b11) begin n_err++; $display("FAIL slot1_active: got %b want 11", active); end
    n_cmp++; if (spawn_x[19:10] !== 10'(m_x[1])) begin n_err++; $display("FAIL slot1_x: got %0d want %0d", spawn_x[19:10], m_x[1]); end
    n_cmp++; if (spawn_y[19:10] !== 10'd0) begin n_err++; $display("FAIL slot1_y: got %0d want 0", spawn_y[19:10]); end
  endtask

  task automatic test_respawn();
    while (edges < 399) tick();
    enemy_y[9:0] = 10'd620;
    tick();
    enemy_y[9:0] = 10'd100;
    n_cmp++; if (spawn_en !== 2'b00) begin n_err++; $display("FAIL respawn_early: got %b want 00", spawn_en); end
    tick();
    n_cmp++; if (spawn_en !== 2'b01 || edges != 401) begin n_err++; $display("FAIL respawn_en: got %b at edge %0d want 01 at 401", spawn_en, edges); end
    n_cmp++; if (spawn_y[9:0] !== 10'd0) begin n_err++; $display("FAIL respawn_y: got %0d want 0", spawn_y[9:0]); end
    n_cmp++; if (spawn_x[9:0] !== 10'(m_x[0])) begin n_err++; $display("FAIL respawn_x: got %0d want %0d", spawn_x[9:0], m_x[0]); end
    n_cmp++; if (active !== 2'b11) begin n_err++; $display("FAIL respawn_active: got %b want 11", active); end
  endtask

  task automatic test_back_to_back();
    repeat (5) tick();
    enemy_y = {10'd620, 10'd620};
    tick();
    enemy_y = {10'd100, 10'd100};
    tick();
    n_cmp++; if (spawn_en !== 2'b01) begin n_err++; $display("FAIL b2b_first: got %b want 01", spawn_en); end
    n_cmp++; if (spawn_x[9:0] !== 10'(m_x[0])) begin n_err++; $display("FAIL b2b_x0: got %0d want %0d", spawn_x[9:0], m_x[0]); end
    tick();
    n_cmp++; if (spawn_en !== 2'b10) begin n_err++; $display("FAIL b2b_second: got %b want 10", spawn_en); end
    n_cmp++; if (spawn_x[19:10] !== 10'(m_x[1])) begin n_err++; $display("FAIL b2b_x1: got %0d want %0d", spawn_x[19:10], m_x[1]); end
    tick();
    n_cmp++; if (spawn_en !== 2'b00) begin n_err++; $display("FAIL b2b_after: got %b want 00", spawn_en); end
  endtask

  task automatic test_collision();
    int bad_en;
    int bad_acc;
    int acc_before;
    enemy_y[19:10] = 10'd620;
    tick();
    enemy_y[19:10] = 10'd100;
    collision = 1'b1;
    acc_before = m_acc;
    bad_en  = 0;
    bad_acc = 0;
    repeat (1000) begin
      tick();
      if (spawn_en !== 2'b00) bad_en++;
      if (acceleration !== 25'(acc_before)) bad_acc++;
    end
    n_cmp++; if (bad_en != 0) begin n_err++; $display("FAIL coll_pulses: got %0d want 0", bad_en); end
    n_cmp++; if (bad_acc != 0) begin n_err++; $display("FAIL coll_accel: got %0d changed cycles want 0", bad_acc); end
    collision = 1'b0;
    tick();
    n_cmp++; if (spawn_en !== 2'b10) begin n_err++; $display("FAIL coll_release: got %b want 10", spawn_en); end
    n_cmp++; if (spawn_x[19:10] !== 10'(m_x[1])) begin n_err++; $display("FAIL coll_x1: got %0d want %0d", spawn_x[19:10], m_x[1]); end
    n_cmp++; if (acceleration !== 25'(m_acc)) begin n_err++; $display("FAIL coll_accel_after: got %0d want %0d", acceleration, m_acc); end
  endtask

  task automatic test_accel();
    reset   = 1'b1;
    enemy_y = {10'd100, 10'd100};
    repeat (2) tick();
    reset = 1'b0;
`ifdef TRAFFIC_ACCEL_EN
    while (edges < 1000) tick();
    n_cmp++; if (acceleration !== 25'd4000) begin n_err++; $display("FAIL accel_4wraps: got %0d want 4000", acceleration); end
    while (edges < 150 * GAP) tick();
    n_cmp++; if (acceleration !== 25'd100000) begin n_err++; $display("FAIL accel_sat: got %0d want 100000", acceleration); end
    repeat (300) tick();
    n_cmp++; if (acceleration !== 25'd100000) begin n_err++; $display("FAIL accel_hold_sat: got %0d want 100000", acceleration); end
`else
    while (edges < 1000) tick();
    n_cmp++; if (acceleration !== 25'd0) begin n_err++; $display("FAIL accel_off: got %0d want 0", acceleration); end
`endif
    reset = 1'b1;
    tick();
    n_cmp++; if (acceleration !== 25'd0) begin n_err++; $display("FAIL accel_reset: got %0d want 0", acceleration); end
  endtask

  task automatic test_single_lane();
    int launches;
    int bad_x;
    int bad_y;
    int cyc;
    reset    = 1'b1;
    enemy_y1 = 10'd620;
    repeat (2) tick();
    reset    = 1'b0;
    launches = 0;
    bad_x    = 0;
    bad_y    = 0;
    cyc      = 0;
    while (launches < 200 && cyc < 1000) begin
      tick();
      cyc++;
      if (spawn_en1 === 1'b1) begin
        launches++;
        if (spawn_x1 !== 10'd197) bad_x++;
        if (spawn_y1 !== 10'd0) bad_y++;
      end
    end
    n_cmp++; if (launches != 200) begin n_err++; $display("FAIL single_count: got %0d launches want 200", launches); end
    n_cmp++; if (bad_x != 0) begin n_err++; $display("FAIL single_x: got %0d off-lane launches want 0", bad_x); end
    n_cmp++; if (bad_y != 0) begin n_err++; $display("FAIL single_y: got %0d bad Y launches want 0", bad_y); end
    enemy_y1 = 10'd100;
  endtask

  task automatic test_random();
    reset     = 1'b1;
    collision = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 19) == 0) collision = ~collision;
      for (int k = 0; k < N; k++)
        enemy_y[10*k +: 10] = ($urandom_range(0, 5) == 0) ? 10'd620 : 10'($urandom_range(0, 619));
      tick();
      n_cmp++; if (spawn_en !== m_en) begin n_err++; $display("FAIL rnd_en@%0d: got %b want %b", i, spawn_en, m_en); end
      n_cmp++; if (active !== m_active) begin n_err++; $display("FAIL rnd_active@%0d: got %b want %b", i, active, m_active); end
      n_cmp++; if (acceleration !== 25'(m_acc)) begin n_err++; $display("FAIL rnd_accel@%0d: got %0d want %0d", i, acceleration, m_acc); end
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (spawn_x[10*k +: 10] !== 10'(m_x[k]) || spawn_y[10*k +: 10] !== 10'(m_y[k])) begin
          n_err++;
          $display("FAIL rnd_xy%0d@%0d: got %0d,%0d want %0d,%0d", k, i,
                   spawn_x[10*k +: 10], spawn_y[10*k +: 10], m_x[k], m_y[k]);
        end
      end
    end
    collision = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_launch();
    test_respawn();
    test_back_to_back();
    test_collision();
    test_accel();
    test_single_lane();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/traffic_spawner.md
# traffic_spawner

Parametrised enemy-traffic scheduler for the racing game. It drives N enemy mover instances. For each one it decides when the enemy is launched, in which lane, and from what Y position, using an on-chip LFSR for lane choice. It also produces the shared acceleration value for the enemy clock divider. It runs in the enemy_clk domain, between the collision ALU (input) and the enemy movers (outputs).

## Interface
- N_ENEMIES, 2: number of enemy slots (1–8).
- N_LANES, 3: number of lanes (1–4).
- LANE_X0, 197: X of lane 0 (left edge of car sprite).
- LANE_PITCH, 82: X step between lanes.
- Y_START, 0: launch Y.
- Y_END, 620: Y at which an enemy counts as off screen; also the parked Y.
- SPAWN_GAP, 250: cycles per gap period.
- ACCEL_STEP, 1000: acceleration increment per gap period.
- ACCEL_MAX, 100000: acceleration ceiling.
- LFSR_SEED, 8'h5A: LFSR reset value (must be non-zero).
- enemy_clk  in  1  block clock.
- reset  in  1  synchronous, active-high.
- collision  in  1  player hit; freezes the block.
- enemy_y  in  10*N_ENEMIES  current Y of each mover; slot k is bits [10k+9:10k].
- spawn_en  out  N_ENEMIES  one-cycle launch pulse per slot.
- spawn_x  out  10*N_ENEMIES  launch X per slot.
- spawn_y  out  10*N_ENEMIES  launch Y per slot.
- active  out  N_ENEMIES  slot has launched at least once since reset.
- acceleration  out  25  value for the enemy clock divider.

## Operation
- Reset values:
  - spawn_en = 0, active = 0, acceleration = 0.
  - spawn_x = LANE_X0 + LANE_PITCH for every slot (clamped to lane 0 if N_LANES = 1).
  - spawn_y = Y_END.
  - gap counter = 0, wrap count = 0, LFSR = LFSR_SEED, all slots PARKED.
- Gap counter: counts 0..SPAWN_GAP-1 and then wraps to 0. Each wrap increments wrap count, which saturates at N_ENEMIES.
- Slot FSM, per slot:
  - PARKED -> PENDING when wrap count ≥ k (so slot 0 is armed immediately).
  - PENDING -> ACTIVE when granted: the slot pulses spawn_en and sets active.
  - ACTIVE -> PENDING in the cycle after enemy_y[k] == Y_END is sampled (exact compare).
- Grant: at most one launch per cycle. The lowest-index PENDING slot wins; other pending slots stay PENDING to the next cycle.
- Lane choice:
  - 8-bit Fibonacci LFSR with taps 8,6,5,4, advancing every non-frozen cycle.
  - lane = lfsr[7:0] mod N_LANES.
  - If the chosen lane equals the previous grant's lane, use (lane+1) mod N_LANES instead. This is skipped when N_LANES = 1.
- Launch values: spawn_x = LANE_X0 + lane*LANE_PITCH and spawn_y = Y_START. Both are written with the pulse and held until the slot's next grant.
- Collision high:
  - Gap counter, LFSR, acceleration and all FSMs hold.
  - spawn_en is forced to 0.
  - PENDING slots stay pending and launch after collision drops.
- Reset has priority over collision and over any in-flight launch.
- Arithmetic: all X/Y values are 10 bits unsigned. Parameter sets where lane X exceeds 1023 are illegal (assert in simulation).

## Timing
- All outputs are registered.
- Latency: enemy_y == Y_END sampled at edge t gives spawn_en high after edge t+1, for one cycle.
- First launch: slot 0 pulses after the 1st edge with reset low.
- Slot k first launches after edge k*SPAWN_GAP + 1, if uncontested.
- Contested grant adds one cycle per lower-index pending slot.
- Collision asserted at edge t: no spawn_en after edge t+1 while collision stays high.

## Configuration
- TRAFFIC_ACCEL_EN defined:
  - Each gap wrap adds ACCEL_STEP to acceleration.
  - acceleration saturates at ACCEL_MAX; it never wraps to 0.
  - Reset clears it.
- TRAFFIC_ACCEL_EN undefined: acceleration is constant 0 and its register and adder are removed.

## Structure
- Package traffic_pkg:
  - slot state enum (PARKED, PENDING, ACTIVE).
  - LFSR tap constant.
  - lane_x(lane) function.
  - 10-bit coordinate typedef.
- Sub-module lane_lfsr: 8-bit LFSR with seed parameter and hold input (tied to collision).
- Top level holds the gap counter, wrap count, slot FSM array, grant arbiter and acceleration register.

## Test plan
- Reset released, defaults, no collision:
  - slot 0 spawn_en after edge 1, spawn_y = 0, spawn_x ∈ {197, 279, 361};
  - slot 1 spawn_en after edge 251.
- Drive enemy_y[0] = 620 at edge 400 -> slot 0 pulses after edge 401 with spawn_y = 0; active stays 11.
- Drive enemy_y[0] and enemy_y[1] to 620 at the same edge -> slot 0 pulses at t+1 and slot 1 at t+2, in different lanes.
- Assert collision for 1000 cycles with slot 1 pending -> no pulses and acceleration unchanged; slot 1 pulses one cycle after collision drops.
- TRAFFIC_ACCEL_EN defined:
  - after 4 wraps (edge 1000), acceleration = 4000;
  - after 150 wraps, acceleration = 100000 (saturated);
  - reset at any point -> 0 after the next edge.
- N_LANES = 1 build, 200 launches -> all spawn_x = 197 and no lane-rotation glitch; 8-lane LFSR sequence is non-zero throughout.
